// File: rtl/otp_ctrl_chk_arb.sv
// Background check arbiter. It serialises the integrity and consistency check
// requests from the LFSR timer onto the OTP partitions, so only one partition
// runs a check at a time. Each grant is guarded by a watchdog. An escalation
// input or a corrupted state register forces the terminal error state.
module otp_ctrl_chk_arb #(
  parameter int NumPart = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumPart-1:0] integ_chk_req_i,
  input  logic [NumPart-1:0] cnsty_chk_req_i,
  output logic [NumPart-1:0] integ_chk_ack_o,
  output logic [NumPart-1:0] cnsty_chk_ack_o,
  output logic [NumPart-1:0] part_chk_go_o,
  output logic               part_chk_integ_o,
  input  logic [NumPart-1:0] part_chk_done_i,
  input  logic               hold_i,
  input  logic [31:0]        timeout_i,
  input  logic [3:0]         escalate_en_i,
  output logic               chk_busy_o,
  output logic               chk_timeout_o,
  output logic               fsm_err_o
);

  localparam int SelW = (NumPart > 1) ? $clog2(NumPart) : 1;

  // Sparse encoding: every pair of legal states differs in four bits, so a
  // single or double bit flip always lands on an unencoded value.
  localparam logic [5:0] IdleSt  = 6'b001011;
  localparam logic [5:0] BusySt  = 6'b110001;
  localparam logic [5:0] AckSt   = 6'b011100;
  localparam logic [5:0] ErrorSt = 6'b100110;

  // Life-cycle multibit Off value; anything else counts as escalation.
  localparam logic [3:0] LcTxOff = 4'b1010;

  logic [5:0]         state_q, state_d;
  logic [SelW-1:0]    sel_q, sel_d;
  logic               type_q, type_d;
  logic [SelW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [31:0]        wdog_q, wdog_d;
  logic               chk_timeout_q, chk_timeout_d;

  logic               escalate;
  logic               any_req;
  logic               pick_type;
  logic [NumPart-1:0] pick_vec;
  logic               pick_found;
  logic [SelW-1:0]    pick_idx;
  logic [SelW-1:0]    scan_idx;

  assign escalate = (escalate_en_i != LcTxOff);
  assign any_req  = (|integ_chk_req_i) | (|cnsty_chk_req_i);

  // Round-robin pick: integrity requests win over consistency requests, and
  // the scan starts at the partition after the last completed grant.
  always_comb begin
    pick_type  = |integ_chk_req_i;
    pick_vec   = pick_type ? integ_chk_req_i : cnsty_chk_req_i;
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = 0; i < NumPart; i++) begin
      scan_idx = SelW'((int'(rr_ptr_q) + i) % NumPart);
      if (!pick_found && pick_vec[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IdleSt;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant bookkeeping: selected partition, grant type, fairness pointer,
  // watchdog and the sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q         <= '0;
      type_q        <= 1'b0;
      rr_ptr_q      <= '0;
      wdog_q        <= '0;
      chk_timeout_q <= 1'b0;
    end else begin
      sel_q         <= sel_d;
      type_q        <= type_d;
      rr_ptr_q      <= rr_ptr_d;
      wdog_q        <= wdog_d;
      chk_timeout_q <= chk_timeout_d;
    end
  end

  // Next-state logic; escalation overrides every other transition.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    type_d        = type_q;
    rr_ptr_d      = rr_ptr_q;
    wdog_d        = wdog_q;
    chk_timeout_d = chk_timeout_q;
    case (state_q)
      IdleSt: begin
        if (!hold_i && any_req) begin
          state_d = BusySt;
          sel_d   = pick_idx;
          type_d  = pick_type;
          wdog_d  = timeout_i;
        end
      end
      BusySt: begin
        // Saturating countdown; the grant keeps running even if the timer
        // withdraws its request, so the ack is always delivered.
        if (wdog_q != 32'd0) begin
          wdog_d = wdog_q - 32'd1;
        end
        if (part_chk_done_i[sel_q]) begin
          state_d  = AckSt;
          rr_ptr_d = SelW'((int'(sel_q) + 1) % NumPart);
        end else if ((timeout_i != 32'd0) && (wdog_q == 32'd0)) begin
          state_d       = ErrorSt;
          chk_timeout_d = 1'b1;
        end
      end
      AckSt: begin
        state_d = IdleSt;
      end
      ErrorSt: begin
        state_d = ErrorSt;
      end
      default: begin
        state_d = ErrorSt;
      end
    endcase
    if (escalate) begin
      state_d = ErrorSt;
    end
  end

  // Output decode from the registered state only, which keeps go one-hot.
  always_comb begin
    integ_chk_ack_o  = '0;
    cnsty_chk_ack_o  = '0;
    part_chk_go_o    = '0;
    part_chk_integ_o = 1'b0;
    chk_busy_o       = 1'b0;
    fsm_err_o        = 1'b0;
    case (state_q)
      IdleSt: begin
      end
      BusySt: begin
        part_chk_go_o[sel_q] = 1'b1;
        part_chk_integ_o     = type_q;
        chk_busy_o           = 1'b1;
      end
      AckSt: begin
        chk_busy_o = 1'b1;
        if (type_q) begin
          integ_chk_ack_o[sel_q] = 1'b1;
        end else begin
          cnsty_chk_ack_o[sel_q] = 1'b1;
        end
      end
      ErrorSt: begin
        // A watchdog expiry is reported on its own flag, not as an FSM error.
        fsm_err_o = ~chk_timeout_q;
      end
      default: begin
        fsm_err_o = 1'b1;
      end
    endcase
    if (escalate) begin
      fsm_err_o = 1'b1;
    end
  end

  assign chk_timeout_o = chk_timeout_q;

endmodule

// File: tb/tb_otp_ctrl_chk_arb.sv
// Bench for otp_ctrl_chk_arb: directed scenarios plus a randomised run, all
// checked every cycle against a phase/elapsed-cycle reference model.
module tb_otp_ctrl_chk_arb;

  localparam int NP = 8;
  localparam logic [3:0] LC_ON  = 4'b0101;
  localparam logic [3:0] LC_OFF = 4'b1010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  integ_req, cnsty_req, done, noise;
  logic        hold;
  logic [31:0] tmo_in;
  logic [3:0]  esc;
  logic [7:0]  iack, cack, go;
  logic        gint, busy, tmo, ferr;

  always #5 clk = ~clk;

  otp_ctrl_chk_arb #(.NumPart(NP)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .integ_chk_req_i (integ_req),
    .cnsty_chk_req_i (cnsty_req),
    .integ_chk_ack_o (iack),
    .cnsty_chk_ack_o (cack),
    .part_chk_go_o   (go),
    .part_chk_integ_o(gint),
    .part_chk_done_i (done),
    .hold_i          (hold),
    .timeout_i       (tmo_in),
    .escalate_en_i   (esc),
    .chk_busy_o      (busy),
    .chk_timeout_o   (tmo),
    .fsm_err_o       (ferr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 idle, 1 granted, 2 acking, 3 dead.
  int   m_ph, m_sel, m_rr, m_el, m_lim;
  logic m_integ, m_tmo;

  logic       auto_done;
  int         done_dly;
  logic [7:0] prev_go;
  int         gq[$];
  logic [7:0] ackq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [7:0] e_go, e_ia, e_ca;
    e_go = (m_ph == 1) ? 8'(1 << m_sel) : 8'h00;
    e_ia = (m_ph == 2 && m_integ) ? 8'(1 << m_sel) : 8'h00;
    e_ca = (m_ph == 2 && !m_integ) ? 8'(1 << m_sel) : 8'h00;
    chk("go", 32'(go), 32'(e_go));
    chk("integ_ack", 32'(iack), 32'(e_ia));
    chk("cnsty_ack", 32'(cack), 32'(e_ca));
    chk("grant_type", 32'(gint), 32'(m_ph == 1 && m_integ));
    chk("busy", 32'(busy), 32'(m_ph == 1 || m_ph == 2));
    chk("timeout", 32'(tmo), 32'(m_tmo));
    chk("fsm_err", 32'(ferr), 32'((esc != LC_OFF) || (m_ph == 3 && !m_tmo)));
  endtask

  task automatic model_step();
    int   vi;
    logic found;
    if (esc != LC_OFF) begin
      m_ph = 3;
    end else begin
      case (m_ph)
        0: if (!hold && (integ_req != 0 || cnsty_req != 0)) begin
          m_integ = (integ_req != 0);
          vi = m_integ ? int'(integ_req) : int'(cnsty_req);
          found = 1'b0;
          for (int k = 0; k < NP; k++) begin
            if (!found && (((vi >> ((m_rr + k) % NP)) & 1) != 0)) begin
              found = 1'b1;
              m_sel = (m_rr + k) % NP;
            end
          end
          m_ph = 1;
          m_el = 0;
          m_lim = int'(tmo_in);
        end
        1: begin
          if (((int'(done) >> m_sel) & 1) != 0) begin
            m_ph = 2;
            m_rr = (m_sel + 1) % NP;
          end else if (tmo_in != 0 && m_el >= m_lim) begin
            m_ph = 3;
            m_tmo = 1'b1;
          end else begin
            m_el++;
          end
        end
        2: m_ph = 0;
        default: ;
      endcase
    end
  endtask

  // One clock cycle: drive partition done, check, advance model, then act as
  // the timer and drop a request bit the cycle after its ack.
  task automatic step();
    logic was_ack, ack_int;
    int   ack_sel;
    done = noise;
    if (auto_done && m_ph == 1 && m_el == done_dly) done = done | 8'(1 << m_sel);
    #1;
    check_outputs();
    if (go != 0 && prev_go == 0) begin
      for (int k = 0; k < NP; k++) if (((int'(go) >> k) & 1) != 0) gq.push_back(k);
    end
    if (iack != 0) ackq.push_back(iack);
    prev_go = go;
    was_ack = (m_ph == 2);
    ack_sel = m_sel;
    ack_int = m_integ;
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (was_ack) begin
      if (ack_int) integ_req = integ_req & ~8'(1 << ack_sel);
      else         cnsty_req = cnsty_req & ~8'(1 << ack_sel);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_ph = 0; m_sel = 0; m_rr = 0; m_el = 0; m_lim = 0;
    m_integ = 1'b0; m_tmo = 1'b0;
    prev_go = 8'h00;
    #1;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    gq.delete();
    ackq.delete();
  endtask

  task automatic run_until_go(input string tag);
    int k = 0;
    while (prev_go == 0 && k < 20) begin step(); k++; end
    chk({tag, "_go_seen"}, 32'(prev_go != 0), 32'd1);
  endtask

  initial begin
    int cnt;
    logic [7:0] r;
    int exp2[9] = '{4, 5, 6, 7, 0, 1, 2, 3, 4};
    integ_req = 0; cnsty_req = 0; done = 0; noise = 0; hold = 0;
    tmo_in = 0; esc = LC_OFF; auto_done = 1'b1; done_dly = 3; rst_n = 1'b1;
    @(negedge clk);

    // Reset state and two integrity grants, 0 then 2.
    do_reset();
    integ_req = 8'h05;
    for (int i = 0; i < 20; i++) step();
    chk("t1_ngrants", 32'(gq.size()), 32'd2);
    if (gq.size() == 2) begin
      chk("t1_grant0", 32'(gq[0]), 32'd0);
      chk("t1_grant1", 32'(gq[1]), 32'd2);
    end
    chk("t1_nacks", 32'(ackq.size()), 32'd2);
    if (ackq.size() == 2) begin
      chk("t1_ack0", 32'(ackq[0]), 32'h01);
      chk("t1_ack1", 32'(ackq[1]), 32'h04);
    end
    chk("t1_rr_ptr", 32'(dut.rr_ptr_q), 32'd3);

    // Integrity first, then all consistency requests starting after the
    // integrity grant on partition 4 moved the pointer to 5.
    do_reset();
    integ_req = 8'h10; cnsty_req = 8'hFF;
    cnt = 0;
    while (gq.size() < 9 && cnt < 150) begin step(); cnt++; end
    chk("t2_ngrants", 32'(gq.size()), 32'd9);
    if (gq.size() == 9) for (int i = 0; i < 9; i++) chk("t2_order", 32'(gq[i]), 32'(exp2[i]));
    for (int i = 0; i < 8; i++) step();
    chk("t2_reqs_drained", 32'({integ_req, cnsty_req}), 32'd0);

    // Hold blocks new grants; release gives go the following cycle.
    do_reset();
    hold = 1'b1; integ_req = 8'h02;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); if (prev_go != 0) cnt++; end
    chk("t3_held_go", 32'(cnt), 32'd0);
    hold = 1'b0;
    step();
    step();
    chk("t3_go_after_release", 32'(prev_go), 32'h02);
    for (int i = 0; i < 8; i++) step();

    // Watchdog expiry with no done.
    do_reset();
    tmo_in = 5; integ_req = 8'h01; auto_done = 1'b0;
    run_until_go("t4");
    cnt = 1;
    while (prev_go != 0 && cnt < 20) begin step(); if (prev_go != 0) cnt++; end
    chk("t4_go_cycles", 32'(cnt), 32'd6);
    chk("t4_timeout", 32'(tmo), 32'd1);
    chk("t4_fsm_err", 32'(ferr), 32'd0);
    for (int i = 0; i < 6; i++) step();

    // Foreign done ignored; own done on the expiry cycle wins.
    do_reset();
    tmo_in = 3; integ_req = 8'h01; auto_done = 1'b1; done_dly = 3; noise = 8'h20;
    for (int i = 0; i < 12; i++) step();
    noise = 8'h00;
    chk("t5_no_timeout", 32'(tmo), 32'd0);
    chk("t5_nacks", 32'(ackq.size()), 32'd1);
    if (ackq.size() == 1) chk("t5_ack", 32'(ackq[0]), 32'h01);

    // Escalation mid-grant.
    do_reset();
    tmo_in = 0; integ_req = 8'h01; auto_done = 1'b0;
    run_until_go("t6");
    step(); step();
    esc = LC_ON;
    #1;
    chk("t6_err_same_cycle", 32'(ferr), 32'd1);
    step();
    chk("t6_go_dropped", 32'(go), 32'd0);
    esc = LC_OFF;
    for (int i = 0; i < 3; i++) step();

    // Reset mid-grant re-arbitrates from pointer 0.
    do_reset();
    integ_req = 8'h81; auto_done = 1'b1; done_dly = 2;
    cnt = 0;
    while (gq.size() < 2 && cnt < 40) begin step(); cnt++; end
    chk("t7_second_grant", 32'(gq.size() == 2 ? gq[1] : -1), 32'd7);
    auto_done = 1'b0;
    integ_req = integ_req | 8'h01;
    step();
    do_reset();
    auto_done = 1'b1;
    run_until_go("t7");
    chk("t7_regrant", 32'(gq.size() > 0 ? gq[0] : -1), 32'd0);
    for (int i = 0; i < 20; i++) step();

    // Randomised traffic with a safe watchdog.
    do_reset();
    tmo_in = 25;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = 8'($urandom) & 8'($urandom);
        if ($urandom_range(0, 1) == 0) integ_req = integ_req | r;
        else                           cnsty_req = cnsty_req | r;
      end
      hold = ($urandom_range(0, 7) == 0);
      noise = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      if (m_ph != 1) done_dly = $urandom_range(0, 6);
      step();
    end
    hold = 1'b0; noise = 8'h00;

    // Corrupted state register.
    do_reset();
    integ_req = 8'h00; cnsty_req = 8'h00;
    force dut.state_q = 6'b000000;
    #1;
    chk("t8_illegal_err", 32'(ferr), 32'd1);
    chk("t8_illegal_go", 32'(go), 32'd0);
    @(posedge clk);
    #1;
    release dut.state_q;
    @(negedge clk);
    #1;
    chk("t8_err_held", 32'(ferr), 32'd1);
    m_ph = 3;
    for (int i = 0; i < 3; i++) step();
    chk("t8_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
